// File: rtl/alarm_sequencer.sv
// Alarm sequencer: three debounced buttons (up/down/go) set a 4-bit countdown
// setpoint, arm a prescaled countdown and raise an alarm when it expires.
// Optional feature macro: ALARM_BLINK_EN -- when defined, the alarm output
// blinks (starts high, toggles on every tick) instead of staying steadily high.
module alarm_sequencer #(
    parameter int DEB_LEN  = 7,
    parameter int PRESCALE = 4
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SET   = 2'd1,
        ARMED = 2'd2,
        ALARM = 2'd3
    } state_t;

    localparam logic [7:0] PRESC_MAX = 8'(PRESCALE - 1);

    // Button bit positions inside the packed button vectors.
    localparam int B_UP = 0;
    localparam int B_DN = 1;
    localparam int B_GO = 2;

    logic clk;
    logic rst;
    logic [2:0] btn_raw;
    logic unused_in;

    assign clk       = io_in[0];
    assign rst       = io_in[1];
    assign btn_raw   = io_in[4:2];
    assign unused_in = ^io_in[7:5];

    logic [2:0][DEB_LEN-1:0] deb_q;
    logic [2:0][DEB_LEN-1:0] deb_d;
    logic [2:0]              full;
    logic [2:0]              full_q;
    logic [2:0]              ev;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] setpoint_q;
    logic [3:0] setpoint_d;
    logic [3:0] remaining_q;
    logic [3:0] remaining_d;
    logic [7:0] presc_q;
    logic [7:0] presc_d;
    logic       tick;
    logic       alarm;

    // Shift each raw button into its own history; an event is the rising
    // edge of "history fully set", so one held press yields one event.
    always_comb begin
        for (int b = 0; b < 3; b++) begin
            deb_d[b] = {deb_q[b][DEB_LEN-2:0], btn_raw[b]};
            full[b]  = &deb_q[b];
        end
        ev = full & ~full_q;
    end

    // Debounce history and previous "fully set" flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_q  <= '0;
            full_q <= '0;
        end else begin
            deb_q  <= deb_d;
            full_q <= full;
        end
    end

    // Tick fires on the prescaler wrap cycle while counting is active.
    always_comb begin
        tick = ((state_q == ARMED) || (state_q == ALARM)) && (presc_q == PRESC_MAX);
    end

    // Next-state logic: go takes priority over up/down; simultaneous
    // up and down cancel each other.
    always_comb begin
        state_d     = state_q;
        setpoint_d  = setpoint_q;
        remaining_d = remaining_q;
        presc_d     = presc_q;
        case (state_q)
            IDLE, SET: begin
                if (ev[B_GO]) begin
                    if (setpoint_q != 4'd0) begin
                        state_d     = ARMED;
                        remaining_d = setpoint_q;
                        presc_d     = 8'd0;
                    end
                end else if (ev[B_UP] && !ev[B_DN]) begin
                    state_d    = SET;
                    setpoint_d = setpoint_q + 4'd1;
                end else if (ev[B_DN] && !ev[B_UP]) begin
                    state_d    = SET;
                    setpoint_d = setpoint_q - 4'd1;
                end
            end
            ARMED: begin
                if (ev[B_GO]) begin
                    state_d     = IDLE;
                    remaining_d = 4'd0;
                    presc_d     = 8'd0;
                end else if (tick) begin
                    presc_d     = 8'd0;
                    remaining_d = remaining_q - 4'd1;
                    if (remaining_q == 4'd1) begin
                        state_d = ALARM;
                    end
                end else begin
                    presc_d = presc_q + 8'd1;
                end
            end
            ALARM: begin
                if (ev[B_GO]) begin
                    state_d = IDLE;
                    presc_d = 8'd0;
                end else if (tick) begin
                    presc_d = 8'd0;
                end else begin
                    presc_d = presc_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, setpoint, countdown and prescaler registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            setpoint_q  <= 4'd0;
            remaining_q <= 4'd0;
            presc_q     <= 8'd0;
        end else begin
            state_q     <= state_d;
            setpoint_q  <= setpoint_d;
            remaining_q <= remaining_d;
            presc_q     <= presc_d;
        end
    end

`ifdef ALARM_BLINK_EN
    logic blink_q;
    logic blink_d;

    // Blink phase: set on entry to ALARM, toggled by each tick while in ALARM.
    always_comb begin
        blink_d = 1'b0;
        if ((state_q == ARMED) && (state_d == ALARM)) begin
            blink_d = 1'b1;
        end else if ((state_q == ALARM) && (state_d == ALARM)) begin
            blink_d = tick ? ~blink_q : blink_q;
        end
    end

    // Blink phase register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_q <= 1'b0;
        end else begin
            blink_q <= blink_d;
        end
    end

    assign alarm = (state_q == ALARM) && blink_q;
`else
    assign alarm = (state_q == ALARM);
`endif

    // Output mapping; everything derives from reset registers so the
    // outputs drop to zero as soon as reset asserts.
    always_comb begin
        io_out = 8'h00;
        case (state_q)
            IDLE, SET: io_out[3:0] = setpoint_q;
            ARMED:     io_out[3:0] = remaining_q;
            default:   io_out[3:0] = 4'd0;
        endcase
        io_out[4] = (state_q == ARMED);
        io_out[5] = alarm;
        io_out[6] = tick;
        io_out[7] = 1'b0;
    end

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed testbench for alarm_sequencer (DEB_LEN=7, PRESCALE=4).
module tb_alarm_sequencer;

    logic       clk;
    logic       rst;
    logic       up;
    logic       dn;
    logic       go;
    logic [2:0] spare;
    logic [7:0] io_in;
    logic [7:0] io_out;
    int         total;
    int         bad;

    assign io_in = {spare, go, dn, up, rst, clk};

    alarm_sequencer #(.DEB_LEN(7), .PRESCALE(4)) dut (
        .io_in  (io_in),
        .io_out (io_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive a clean press long enough to register, then release; returns
    // just after the edge at which the event takes effect.
    task automatic press(input logic u, input logic d, input logic g);
        up = u; dn = d; go = g;
        cyc(7);
        up = 1'b0; dn = 1'b0; go = 1'b0;
        cyc(1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        up = 1'b0; dn = 1'b0; go = 1'b0;
        cyc(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        up = 1'b0; dn = 1'b0; go = 1'b0; spare = 3'b111;
        #1;
        total++;
        if (io_out !== 8'h00) begin
            bad++;
            $display("FAIL reset_async got=%h exp=00", io_out);
        end
        cyc(3);
        total++;
        if (io_out !== 8'h00) begin
            bad++;
            $display("FAIL reset_held got=%h exp=00", io_out);
        end
        rst = 1'b0;
        cyc(1);
        total++;
        if (io_out !== 8'h00) begin
            bad++;
            $display("FAIL reset_release got=%h exp=00", io_out);
        end
    endtask

    task automatic test_debounce();
        // Button held through reset release needs full samples afterwards.
        up = 1'b1;
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(7);
        total++;
        if (io_out !== 8'h00) begin
            bad++;
            $display("FAIL deb_early got=%h exp=00", io_out);
        end
        cyc(1);
        total++;
        if (io_out !== 8'h01) begin
            bad++;
            $display("FAIL deb_event got=%h exp=01", io_out);
        end
        cyc(2);
        up = 1'b0;
        cyc(9);
        total++;
        if (io_out !== 8'h01) begin
            bad++;
            $display("FAIL deb_single got=%h exp=01", io_out);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] exp_v [5];
        logic       ups   [5];
        exp_v[0] = 4'd15; ups[0] = 1'b0;
        exp_v[1] = 4'd14; ups[1] = 1'b0;
        exp_v[2] = 4'd15; ups[2] = 1'b1;
        exp_v[3] = 4'd0;  ups[3] = 1'b1;
        exp_v[4] = 4'd1;  ups[4] = 1'b1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            press(ups[i], ~ups[i], 1'b0);
            total++;
            if (io_out !== {4'h0, exp_v[i]}) begin
                bad++;
                $display("FAIL wrap_%0d got=%h exp=%h", i, io_out, {4'h0, exp_v[i]});
            end
        end
    endtask

    task automatic test_glitch_simul();
        // Setpoint is 1 here, state SET.
        go = 1'b1;
        cyc(3);
        go = 1'b0;
        cyc(10);
        total++;
        if (io_out !== 8'h01) begin
            bad++;
            $display("FAIL glitch_go got=%h exp=01", io_out);
        end
        press(1'b1, 1'b1, 1'b0);
        cyc(2);
        total++;
        if (io_out !== 8'h01) begin
            bad++;
            $display("FAIL up_dn_same got=%h exp=01", io_out);
        end
    endtask

    task automatic test_go_zero();
        do_reset();
        press(1'b0, 1'b0, 1'b1);
        cyc(3);
        total++;
        if (io_out !== 8'h00) begin
            bad++;
            $display("FAIL go_zero got=%h exp=00", io_out);
        end
    endtask

    task automatic test_countdown();
        logic [7:0] exp_o;
        logic       exp_alarm;
        do_reset();
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        total++;
        if (io_out !== 8'h13) begin
            bad++;
            $display("FAIL arm_entry got=%h exp=13", io_out);
        end
        for (int i = 1; i <= 21; i++) begin
            cyc(1);
            exp_o = 8'h00;
            exp_o[6] = ((i % 4) == 3);
            if (i < 12) begin
                exp_o[4]   = 1'b1;
                exp_o[3:0] = 4'(3 - i / 4);
            end else begin
`ifdef ALARM_BLINK_EN
                exp_alarm = (((i - 12) / 4) % 2) == 0;
`else
                exp_alarm = 1'b1;
`endif
                exp_o[5] = exp_alarm;
            end
            total++;
            if (io_out !== exp_o) begin
                bad++;
                $display("FAIL count_%0d got=%h exp=%h", i, io_out, exp_o);
            end
        end
        // Asynchronous reset in the middle of a clock phase.
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (io_out !== 8'h00) begin
            bad++;
            $display("FAIL alarm_reset got=%h exp=00", io_out);
        end
        cyc(2);
        total++;
        if (io_out !== 8'h00) begin
            bad++;
            $display("FAIL alarm_reset_hold got=%h exp=00", io_out);
        end
        rst = 1'b0;
    endtask

    task automatic test_cancel();
        do_reset();
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        // Second go press starts right after arming; takes effect 8 edges later.
        go = 1'b1;
        cyc(7);
        go = 1'b0;
        total++;
        if (io_out !== 8'h52) begin
            bad++;
            $display("FAIL cancel_before got=%h exp=52", io_out);
        end
        cyc(1);
        total++;
        if (io_out !== 8'h03) begin
            bad++;
            $display("FAIL cancel_after got=%h exp=03", io_out);
        end
        cyc(10);
        total++;
        if (io_out !== 8'h03) begin
            bad++;
            $display("FAIL cancel_stays got=%h exp=03", io_out);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        spare = 3'b000;
        test_reset();
        test_debounce();
        test_wrap();
        test_glitch_simul();
        test_go_zero();
        test_countdown();
        test_cancel();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
